// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared types and helpers for the cache/AXI bridge arbiter
package cache_arb_pkg;

  localparam int unsigned DEF_RD_BEATS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    REL    = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  // Writes are always a single beat; reads are a full line unless arlenone is set.
  function automatic int unsigned load_beats(input logic        is_rd,
                                             input logic        arlenone,
                                             input int unsigned rd_beats);
    if (!is_rd) return 1;
    return arlenone ? 1 : rd_beats;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin picker
// Bit 0 is the I-cache, bit 1 the D-cache; on a tie the side that did not win last is picked.
module rr_arb2
  import cache_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  req_id_e    i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = (i_last == REQ_I) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/cache_axi_arbiter.sv
// rtl/cache_axi_arbiter.sv - shares the AXI master bridge between I-cache and D-cache
// Grants one requester, forwards its fields to the bridge and holds the grant until all beats return.
module cache_axi_arbiter
  import cache_arb_pkg::*;
#(
  parameter int          DATA_BITS = 32,
  parameter int          TYPE_BITS = 3,
  parameter int unsigned RD_BEATS  = DEF_RD_BEATS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_crreq_i,
  input  logic                 i_arlenone_i,
  input  logic [DATA_BITS-1:0] i_caddr_i,
  output logic                 i_wait_o,
  input  logic                 d_crreq_i,
  input  logic                 d_cwreq_i,
  input  logic                 d_arlenone_i,
  input  logic [TYPE_BITS-1:0] d_cwtype_i,
  input  logic [DATA_BITS-1:0] d_cdatain_i,
  input  logic [DATA_BITS-1:0] d_caddr_i,
  output logic                 d_wait_o,
  output logic [DATA_BITS-1:0] dataout_o,
  output logic                 m_crreq_o,
  output logic                 m_cwreq_o,
  output logic                 m_arlenone_o,
  output logic [TYPE_BITS-1:0] m_cwtype_o,
  output logic [DATA_BITS-1:0] m_cdatain_o,
  output logic [DATA_BITS-1:0] m_caddr_o,
  input  logic                 m_wait_i,
  input  logic [DATA_BITS-1:0] m_dataout_i
);

  localparam int CNT_W = $clog2(RD_BEATS + 1);

  arb_state_e           r_state;
  logic [CNT_W-1:0]     r_beat_cnt;
  req_id_e              r_last;
  logic                 r_d_is_rd;
  logic                 r_arlenone;
  logic [TYPE_BITS-1:0] r_cwtype;
  logic [DATA_BITS-1:0] r_cdatain;
  logic [DATA_BITS-1:0] r_caddr;

  logic                 w_i_act;
  logic                 w_d_act;
  logic [1:0]           w_gnt;
  logic                 w_drive;
  logic                 w_sel_d;
  logic                 w_d_rd;
  logic                 w_crreq;
  logic                 w_cwreq;
  logic                 w_arlenone;
  logic [TYPE_BITS-1:0] w_cwtype;
  logic [DATA_BITS-1:0] w_cdatain;
  logic [DATA_BITS-1:0] w_caddr;

  assign w_i_act = i_crreq_i;
  assign w_d_act = d_crreq_i | d_cwreq_i;

  rr_arb2 u_rr_arb2 (
    .i_req  ({w_d_act, w_i_act}),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  // In IDLE the picker's choice drives the bridge in the same cycle; reset blanks the port.
  always_comb begin
    w_drive = 1'b0;
    w_sel_d = 1'b0;
    w_d_rd  = d_crreq_i;
    case (r_state)
      IDLE: begin
        w_drive = |w_gnt;
        w_sel_d = w_gnt[1];
      end
      BUSY_I: w_drive = 1'b1;
      BUSY_D: begin
        w_drive = 1'b1;
        w_sel_d = 1'b1;
        w_d_rd  = r_d_is_rd;
      end
      default: w_drive = 1'b0;
    endcase
    w_drive = w_drive & rst;
  end

  // A D-cache read beats a simultaneous write; the write is picked up in a later arbitration.
  always_comb begin
    if (w_sel_d) begin
      w_crreq    = w_d_rd & d_crreq_i;
      w_cwreq    = ~w_d_rd & d_cwreq_i;
      w_arlenone = d_arlenone_i;
      w_cwtype   = d_cwtype_i;
      w_cdatain  = d_cdatain_i;
      w_caddr    = d_caddr_i;
    end else begin
      w_crreq    = i_crreq_i;
      w_cwreq    = 1'b0;
      w_arlenone = i_arlenone_i;
      w_cwtype   = '0;
      w_cdatain  = '0;
      w_caddr    = i_caddr_i;
    end
  end

  assign m_crreq_o    = w_drive & w_crreq;
  assign m_cwreq_o    = w_drive & w_cwreq;
  assign m_arlenone_o = w_drive ? w_arlenone : r_arlenone;
  assign m_cwtype_o   = w_drive ? w_cwtype   : r_cwtype;
  assign m_cdatain_o  = w_drive ? w_cdatain  : r_cdatain;
  assign m_caddr_o    = w_drive ? w_caddr    : r_caddr;
  assign dataout_o    = m_dataout_i;

  assign i_wait_o = (r_state == BUSY_I) ? m_wait_i : w_i_act;
  assign d_wait_o = (r_state == BUSY_D) ? m_wait_i : w_d_act;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
      r_last     <= REQ_I;
      r_d_is_rd  <= 1'b0;
      r_arlenone <= 1'b0;
      r_cwtype   <= '0;
      r_cdatain  <= '0;
      r_caddr    <= '0;
    end else begin
      if (w_drive) begin
        r_arlenone <= w_arlenone;
        r_cwtype   <= w_cwtype;
        r_cdatain  <= w_cdatain;
        r_caddr    <= w_caddr;
      end
      case (r_state)
        IDLE: begin
          if (w_gnt[1]) begin
            r_state    <= BUSY_D;
            r_last     <= REQ_D;
            r_d_is_rd  <= d_crreq_i;
            r_beat_cnt <= CNT_W'(load_beats(d_crreq_i, d_arlenone_i, RD_BEATS));
          end else if (w_gnt[0]) begin
            r_state    <= BUSY_I;
            r_last     <= REQ_I;
            r_beat_cnt <= CNT_W'(load_beats(1'b1, i_arlenone_i, RD_BEATS));
          end
        end
        BUSY_I, BUSY_D: begin
          if (r_beat_cnt == '0) begin
            r_state <= REL;
          end else if (!m_wait_i) begin
            r_beat_cnt <= r_beat_cnt - CNT_W'(1);
            if (r_beat_cnt == CNT_W'(1)) r_state <= REL;
          end
        end
        REL:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // The winner must keep its request up until its last beat has returned.
  a_i_hold: assert property (@(posedge clk) disable iff (!rst)
    (r_state == BUSY_I) |-> i_crreq_i);
  a_d_hold: assert property (@(posedge clk) disable iff (!rst)
    (r_state == BUSY_D) |-> (r_d_is_rd ? d_crreq_i : d_cwreq_i));

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// tb/tb_cache_axi_arbiter.sv - scoreboard bench for the cache/AXI bridge arbiter
module tb_cache_axi_arbiter;

  localparam int DW = 32;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_crreq_i, i_arlenone_i, i_wait_o;
  logic [DW-1:0] i_caddr_i;
  logic          d_crreq_i, d_cwreq_i, d_arlenone_i, d_wait_o;
  logic [TW-1:0] d_cwtype_i;
  logic [DW-1:0] d_cdatain_i, d_caddr_i;
  logic [DW-1:0] dataout_o;
  logic          m_crreq_o, m_cwreq_o, m_arlenone_o;
  logic [TW-1:0] m_cwtype_o;
  logic [DW-1:0] m_cdatain_o, m_caddr_o;
  logic          m_wait_i;
  logic [DW-1:0] m_dataout_i;

  always #5 clk = ~clk;

  cache_axi_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_crreq_i    (i_crreq_i),
    .i_arlenone_i (i_arlenone_i),
    .i_caddr_i    (i_caddr_i),
    .i_wait_o     (i_wait_o),
    .d_crreq_i    (d_crreq_i),
    .d_cwreq_i    (d_cwreq_i),
    .d_arlenone_i (d_arlenone_i),
    .d_cwtype_i   (d_cwtype_i),
    .d_cdatain_i  (d_cdatain_i),
    .d_caddr_i    (d_caddr_i),
    .d_wait_o     (d_wait_o),
    .dataout_o    (dataout_o),
    .m_crreq_o    (m_crreq_o),
    .m_cwreq_o    (m_cwreq_o),
    .m_arlenone_o (m_arlenone_o),
    .m_cwtype_o   (m_cwtype_o),
    .m_cdatain_o  (m_cdatain_o),
    .m_caddr_o    (m_caddr_o),
    .m_wait_i     (m_wait_i),
    .m_dataout_i  (m_dataout_i)
  );

  typedef struct {
    bit            is_d;
    bit            rd;
    logic [DW-1:0] addr;
    bit            arl;
    logic [DW-1:0] data;
    logic [TW-1:0] typ;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit is_d, input bit rd, input logic [DW-1:0] addr, input bit arl,
                      input logic [DW-1:0] data, input logic [TW-1:0] typ, input int n);
    exp_t e;
    e.is_d = is_d; e.rd = rd; e.addr = addr; e.arl = arl; e.data = data; e.typ = typ;
    repeat (n) sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    m_dataout_i = $urandom;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Every beat the bridge completes is matched against the queue of expected beats.
  always @(negedge clk) begin
    if (rst && (m_crreq_o || m_cwreq_o)) begin
      chk("both_req_high", {31'b0, m_crreq_o & m_cwreq_o}, 32'd0);
      if (!m_wait_i) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: addr 0x%08h with nothing queued", m_caddr_o);
        end else begin
          mon_e = sbq.pop_front();
          chk("beat_crreq", {31'b0, m_crreq_o}, {31'b0, mon_e.rd});
          chk("beat_cwreq", {31'b0, m_cwreq_o}, {31'b0, !mon_e.rd});
          chk("beat_addr", m_caddr_o, mon_e.addr);
          chk("beat_rdata", dataout_o, m_dataout_i);
          if (mon_e.rd) chk("beat_arlenone", {31'b0, m_arlenone_o}, {31'b0, mon_e.arl});
          else begin
            chk("beat_wdata", m_cdatain_o, mon_e.data);
            chk("beat_wtype", {29'b0, m_cwtype_o}, {29'b0, mon_e.typ});
          end
          if (mon_e.is_d) chk("beat_d_wait", {31'b0, d_wait_o}, 32'd0);
          else            chk("beat_i_wait", {31'b0, i_wait_o}, 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit b;
    i_crreq_i = 0; i_arlenone_i = 0; i_caddr_i = '0;
    d_crreq_i = 0; d_cwreq_i = 0; d_arlenone_i = 0; d_cwtype_i = '0;
    d_cdatain_i = '0; d_caddr_i = '0;
    m_wait_i = 1; m_dataout_i = '0;

    neg();
    chk("rst_m_crreq", {31'b0, m_crreq_o}, 0);
    chk("rst_m_cwreq", {31'b0, m_cwreq_o}, 0);
    chk("rst_m_caddr", m_caddr_o, 0);
    chk("rst_i_wait", {31'b0, i_wait_o}, 0);
    chk("rst_d_wait", {31'b0, d_wait_o}, 0);
    step(); step();
    rst = 1;

    // Tie right after reset: D first, then I, then D again.
    step();
    i_crreq_i = 1; i_arlenone_i = 1; i_caddr_i = 32'h300;
    d_crreq_i = 1; d_arlenone_i = 1; d_caddr_i = 32'h4000;
    push(1, 1, 32'h4000, 1, 0, 0, 1);
    push(0, 1, 32'h300, 1, 0, 0, 1);
    neg();
    chk("t3_first_addr", m_caddr_o, 32'h4000);
    chk("t3_first_crreq", {31'b0, m_crreq_o}, 1);
    chk("t3_i_wait0", {31'b0, i_wait_o}, 1);
    chk("t3_d_wait0", {31'b0, d_wait_o}, 1);
    step(); m_wait_i = 0; neg();
    chk("t3_i_wait_busy", {31'b0, i_wait_o}, 1);
    step(); m_wait_i = 1; d_crreq_i = 0; neg();
    chk("t3_rel_crreq", {31'b0, m_crreq_o}, 0);
    chk("t3_rel_i_wait", {31'b0, i_wait_o}, 1);
    step(); neg();
    chk("t3_second_addr", m_caddr_o, 32'h300);
    chk("t3_second_i_wait", {31'b0, i_wait_o}, 1);
    step(); m_wait_i = 0; neg();
    step(); m_wait_i = 1; i_crreq_i = 0; neg();
    chk("t3_rel2_crreq", {31'b0, m_crreq_o}, 0);
    step();
    i_crreq_i = 1; i_caddr_i = 32'h310;
    d_crreq_i = 1; d_caddr_i = 32'h4010;
    push(1, 1, 32'h4010, 1, 0, 0, 1);
    neg();
    chk("t3_third_addr", m_caddr_o, 32'h4010);
    step(); m_wait_i = 0; neg();
    step(); m_wait_i = 1; d_crreq_i = 0; i_crreq_i = 0; neg();
    step(); neg();
    chk("t3_idle_crreq", {31'b0, m_crreq_o}, 0);

    // I full-line read with beats on cycles 3,5,6,8.
    step();
    i_crreq_i = 1; i_arlenone_i = 0; i_caddr_i = 32'h100;
    push(0, 1, 32'h100, 0, 0, 0, 4);
    neg();
    chk("t1_c0_crreq", {31'b0, m_crreq_o}, 1);
    chk("t1_c0_addr", m_caddr_o, 32'h100);
    chk("t1_c0_i_wait", {31'b0, i_wait_o}, 1);
    for (int c = 1; c <= 8; c++) begin
      b = (c == 3) || (c == 5) || (c == 6) || (c == 8);
      step(); m_wait_i = !b; neg();
      chk("t1_i_wait", {31'b0, i_wait_o}, {31'b0, !b});
    end
    step(); m_wait_i = 1; neg();
    chk("t1_rel_crreq", {31'b0, m_crreq_o}, 0);
    chk("t1_rel_i_wait", {31'b0, i_wait_o}, 1);
    chk("t1_rel_addr_held", m_caddr_o, 32'h100);
    step(); i_crreq_i = 0; neg();
    chk("t1_idle_i_wait", {31'b0, i_wait_o}, 0);

    // D single write.
    step();
    d_cwreq_i = 1; d_caddr_i = 32'h2000; d_cdatain_i = 32'hDEADBEEF; d_cwtype_i = 3'b001;
    d_arlenone_i = 0;
    push(1, 0, 32'h2000, 0, 32'hDEADBEEF, 3'b001, 1);
    neg();
    chk("t2_cwreq", {31'b0, m_cwreq_o}, 1);
    chk("t2_crreq", {31'b0, m_crreq_o}, 0);
    chk("t2_wdata", m_cdatain_o, 32'hDEADBEEF);
    chk("t2_i_wait0", {31'b0, i_wait_o}, 0);
    chk("t2_d_wait0", {31'b0, d_wait_o}, 1);
    step(); m_wait_i = 0; neg();
    chk("t2_i_wait1", {31'b0, i_wait_o}, 0);
    step(); m_wait_i = 1; neg();
    chk("t2_rel_cwreq", {31'b0, m_cwreq_o}, 0);
    chk("t2_rel_d_wait", {31'b0, d_wait_o}, 1);
    chk("t2_rel_i_wait", {31'b0, i_wait_o}, 0);
    chk("t2_rel_wdata_held", m_cdatain_o, 32'hDEADBEEF);
    step(); d_cwreq_i = 0; neg();
    chk("t2_idle_d_wait", {31'b0, d_wait_o}, 0);

    // D read and write together: read first, write after REL.
    step();
    d_crreq_i = 1; d_cwreq_i = 1; d_arlenone_i = 1; d_caddr_i = 32'h5000;
    d_cdatain_i = 32'h12345678; d_cwtype_i = 3'b010;
    push(1, 1, 32'h5000, 1, 0, 0, 1);
    push(1, 0, 32'h5000, 1, 32'h12345678, 3'b010, 1);
    neg();
    chk("t4_rd_crreq", {31'b0, m_crreq_o}, 1);
    chk("t4_rd_cwreq", {31'b0, m_cwreq_o}, 0);
    step(); m_wait_i = 0; neg();
    step(); m_wait_i = 1; d_crreq_i = 0; neg();
    chk("t4_rel_cwreq", {31'b0, m_cwreq_o}, 0);
    chk("t4_rel_d_wait", {31'b0, d_wait_o}, 1);
    step(); neg();
    chk("t4_wr_cwreq", {31'b0, m_cwreq_o}, 1);
    chk("t4_wr_crreq", {31'b0, m_crreq_o}, 0);
    step(); m_wait_i = 0; neg();
    step(); m_wait_i = 1; d_cwreq_i = 0; neg();

    // I single-beat read with D write queued behind it.
    step();
    i_crreq_i = 1; i_arlenone_i = 1; i_caddr_i = 32'h600;
    d_cwreq_i = 1; d_caddr_i = 32'h7000; d_cdatain_i = 32'hCAFEF00D; d_cwtype_i = 3'b100;
    push(0, 1, 32'h600, 1, 0, 0, 1);
    push(1, 0, 32'h7000, 0, 32'hCAFEF00D, 3'b100, 1);
    neg();
    chk("t6_i_addr", m_caddr_o, 32'h600);
    chk("t6_d_wait0", {31'b0, d_wait_o}, 1);
    step(); m_wait_i = 0; neg();
    chk("t6_d_wait1", {31'b0, d_wait_o}, 1);
    step(); m_wait_i = 1; i_crreq_i = 0; neg();
    chk("t6_rel_crreq", {31'b0, m_crreq_o}, 0);
    chk("t6_rel_cwreq", {31'b0, m_cwreq_o}, 0);
    step(); neg();
    chk("t6_d_cwreq", {31'b0, m_cwreq_o}, 1);
    chk("t6_d_addr", m_caddr_o, 32'h7000);
    step(); m_wait_i = 0; neg();
    step(); m_wait_i = 1; d_cwreq_i = 0; neg();

    // Reset in the middle of an I burst with two beats left.
    step();
    i_crreq_i = 1; i_arlenone_i = 0; i_caddr_i = 32'h800;
    push(0, 1, 32'h800, 0, 0, 0, 2);
    neg();
    step(); m_wait_i = 0; neg();
    step(); neg();
    step(); m_wait_i = 1; rst = 0;
    #1;
    chk("t5_rst_crreq", {31'b0, m_crreq_o}, 0);
    chk("t5_rst_addr", m_caddr_o, 0);
    chk("t5_rst_i_wait", {31'b0, i_wait_o}, 1);
    i_crreq_i = 0;
    neg();
    chk("t5_rst_i_wait_idle", {31'b0, i_wait_o}, 0);
    step(); rst = 1; neg();
    chk("t5_post_crreq", {31'b0, m_crreq_o}, 0);
    step();
    d_crreq_i = 1; d_arlenone_i = 1; d_caddr_i = 32'h9000;
    push(1, 1, 32'h9000, 1, 0, 0, 1);
    neg();
    chk("t5_new_crreq", {31'b0, m_crreq_o}, 1);
    chk("t5_new_addr", m_caddr_o, 32'h9000);
    step(); m_wait_i = 0; neg();
    step(); m_wait_i = 1; d_crreq_i = 0; neg();
    step(); neg();

    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
